// File: rtl/approx_adder_sweep_ctrl_pkg.sv
// Shared types and width helpers for the approximate-adder sweep controller.
// Optional sum_ed accumulator is enabled with SWEEP_SUM_ED_EN.
package approx_adder_sweep_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_e;

    localparam int DRAIN_CYCLES = 2;

    function automatic int err_w(input int w);
        return 2 * w + 1;
    endfunction

    function automatic int max_w(input int w);
        return w + 1;
    endfunction

    function automatic int sum_w(input int w);
        return 3 * w + 1;
    endfunction

endpackage

// File: rtl/approx_adder_sweep_ctrl_if.sv
// Control/result bundle between a sweep requester and the sweep controller.
// sum_ed only exists when SWEEP_SUM_ED_EN is defined.
interface approx_adder_sweep_ctrl_if #(
    parameter int WIDTH = 8
);
    import approx_adder_sweep_ctrl_pkg::*;

    logic                      start;
    logic                      cin_sel;
    logic                      busy;
    logic                      done;
    logic [err_w(WIDTH)-1:0]   err_count;
    logic [max_w(WIDTH)-1:0]   max_ed;
`ifdef SWEEP_SUM_ED_EN
    logic [sum_w(WIDTH)-1:0]   sum_ed;

    modport master (
        output start, cin_sel,
        input  busy, done, err_count, max_ed, sum_ed
    );
    modport slave (
        input  start, cin_sel,
        output busy, done, err_count, max_ed, sum_ed
    );
`else
    modport master (
        output start, cin_sel,
        input  busy, done, err_count, max_ed
    );
    modport slave (
        input  start, cin_sel,
        output busy, done, err_count, max_ed
    );
`endif

endinterface

// File: rtl/approx_adder_sweep_ctrl_or_adder.sv
// Adder whose two LSBs are approximated by OR; the upper part is exact and
// takes A[1]&B[1] as its carry-in. Cin is folded into bit 0 by OR.
module LSB_Two_AproximateORAdder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] S,
    output logic             Cout
);

    assign S[1:0] = {A[1] | B[1], A[0] | B[0] | Cin};

    assign {Cout, S[WIDTH-1:2]} = {1'b0, A[WIDTH-1:2]}
                                + {1'b0, B[WIDTH-1:2]}
                                + {{(WIDTH - 2){1'b0}}, A[1] & B[1]};

endmodule

// File: rtl/approx_adder_sweep_ctrl.sv
// Exhaustive sweep of the LSB-OR approximate adder against an exact sum,
// accumulating error statistics. sum_ed exists only with SWEEP_SUM_ED_EN.
module approx_adder_sweep_ctrl #(
    parameter int WIDTH = 8
) (
    input logic                      clk,
    input logic                      rst,
    approx_adder_sweep_ctrl_if.slave bus
);
    import approx_adder_sweep_ctrl_pkg::*;

    localparam int IW = 2 * WIDTH;
    localparam int EW = err_w(WIDTH);
    localparam int MW = max_w(WIDTH);

    state_e           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [1:0]       drain_q, drain_d;
    logic             cin_q, cin_d;
    logic             clear;

    logic [WIDTH-1:0] a1_q, b1_q;
    logic             c1_q, v1_q;
    logic [WIDTH:0]   apx2_q, ex2_q;
    logic             v2_q;

    logic [WIDTH-1:0] apx_s;
    logic             apx_c;
    logic [WIDTH:0]   exact;
    logic [WIDTH:0]   ed;

    logic [EW-1:0]    err_q, err_d;
    logic [MW-1:0]    max_q, max_d;
`ifdef SWEEP_SUM_ED_EN
    localparam int SW = sum_w(WIDTH);
    logic [SW-1:0]    sum_q, sum_d;
`endif

    LSB_Two_AproximateORAdder #(.WIDTH(WIDTH)) u_apx (
        .A    (a1_q),
        .B    (b1_q),
        .Cin  (c1_q),
        .S    (apx_s),
        .Cout (apx_c)
    );

    assign exact = {1'b0, a1_q} + {1'b0, b1_q} + {{WIDTH{1'b0}}, c1_q};

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        drain_d  = drain_q;
        cin_d    = cin_q;
        clear    = 1'b0;
        bus.busy = (state_q == RUN) || (state_q == DRAIN);
        bus.done = (state_q == DONE);
        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = RUN;
                    idx_d   = '0;
                    cin_d   = bus.cin_sel;
                    clear   = 1'b1;
                end
            end
            RUN: begin
                // Last pair issued: hold idx so pair 0 is never reissued
                if (&idx_q) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DRAIN: begin
                if (drain_q == 2'(DRAIN_CYCLES - 1)) state_d = DONE;
                else drain_d = drain_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ed    = (ex2_q >= apx2_q) ? ex2_q - apx2_q : apx2_q - ex2_q;
        err_d = err_q;
        max_d = max_q;
`ifdef SWEEP_SUM_ED_EN
        sum_d = sum_q;
`endif
        if (clear) begin
            err_d = '0;
            max_d = '0;
`ifdef SWEEP_SUM_ED_EN
            sum_d = '0;
`endif
        end else if (v2_q) begin
            if (ed != '0) err_d = err_q + 1'b1;
            if (ed > max_q) max_d = ed;
`ifdef SWEEP_SUM_ED_EN
            sum_d = sum_q + SW'(ed);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            drain_q <= '0;
            cin_q   <= 1'b0;
            a1_q    <= '0;
            b1_q    <= '0;
            c1_q    <= 1'b0;
            v1_q    <= 1'b0;
            apx2_q  <= '0;
            ex2_q   <= '0;
            v2_q    <= 1'b0;
            err_q   <= '0;
            max_q   <= '0;
`ifdef SWEEP_SUM_ED_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            drain_q <= drain_d;
            cin_q   <= cin_d;
            a1_q    <= idx_q[IW-1:WIDTH];
            b1_q    <= idx_q[WIDTH-1:0];
            c1_q    <= cin_q;
            v1_q    <= (state_q == RUN);
            apx2_q  <= {apx_c, apx_s};
            ex2_q   <= exact;
            v2_q    <= v1_q;
            err_q   <= err_d;
            max_q   <= max_d;
`ifdef SWEEP_SUM_ED_EN
            sum_q   <= sum_d;
`endif
        end
    end

    assign bus.err_count = err_q;
    assign bus.max_ed    = max_q;
`ifdef SWEEP_SUM_ED_EN
    assign bus.sum_ed    = sum_q;
`endif

endmodule
